// File: rtl/add_sched_if.sv
// Requester/adder signal bundle for add_sched: the scheduler takes the slave modport,
// and the requesters plus the shared adder take the master modport.
interface add_sched_if #(
  parameter int N_REQ = 4,
  parameter int W     = 16
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] op_a;
  logic [N_REQ*W-1:0] op_b;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [W-1:0]       result;
  logic               err;
  logic               busy;
  logic               add_cs;
  logic [W-1:0]       add_x;
  logic [W-1:0]       add_y;
  logic [W-1:0]       add_sum;
  logic               add_rdy;

  modport slave (
    input  req, op_a, op_b, add_sum, add_rdy,
    output gnt, done, result, err, busy, add_cs, add_x, add_y
  );

  modport master (
    output req, op_a, op_b, add_sum, add_rdy,
    input  gnt, done, result, err, busy, add_cs, add_x, add_y
  );
endinterface

// File: rtl/add_sched.sv
// Round-robin scheduler giving N_REQ requesters access to one shared sign-magnitude adder.
// Optional handshake watchdog enabled by defining ADD_SCHED_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no operation; arbitrate among req
// ISSUE   | operands latched, add_cs high for this cycle
// WAIT_LO | wait for the adder to drop add_rdy
// WAIT_HI | wait for add_rdy to return with the sum
// DONE    | done pulse to the winner, then release the grant
module add_sched #(
  parameter int N_REQ   = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst_n,
  add_sched_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_win;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic [W-1:0]     r_result;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic             r_cs;

  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  logic [W-1:0]     w_opa;
  logic [W-1:0]     w_opb;
  logic             w_fail;

  // Scan from r_ptr upward with wrap; the first active request found wins.
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    w_idx = r_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_any && bus.req[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
      w_idx = (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  always_comb begin
    w_opa = '0;
    w_opb = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (PW'(k) == w_win) begin
        w_opa = bus.op_a[k*W +: W];
        w_opb = bus.op_b[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_cs     <= 1'b0;
    end else begin
      r_cs   <= 1'b0;
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win   <= w_win;
            r_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
            r_x     <= w_opa;
            r_y     <= w_opb;
            r_cs    <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: r_state <= WAIT_LO;
        WAIT_LO: begin
          if (!bus.add_rdy) begin
            r_state <= WAIT_HI;
          end else if (w_fail) begin
            r_result <= '0;
            r_done   <= r_gnt;
            r_state  <= DONE;
          end
        end
        WAIT_HI: begin
          if (bus.add_rdy) begin
            r_result <= bus.add_sum;
            r_done   <= r_gnt;
            r_state  <= DONE;
          end else if (w_fail) begin
            r_result <= '0;
            r_done   <= r_gnt;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_gnt   <= '0;
          r_ptr   <= (r_win == PW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ADD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_tcnt;
  logic          r_err;

  // Counter restarts on entry to each wait phase; a phase fails after TIMEOUT cycles in it.
  assign w_fail = ((r_state == WAIT_LO && bus.add_rdy) || (r_state == WAIT_HI && !bus.add_rdy))
                  && (r_tcnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ISSUE || (r_state == WAIT_LO && !bus.add_rdy))
        r_tcnt <= '0;
      else if (r_state == WAIT_LO || r_state == WAIT_HI)
        r_tcnt <= r_tcnt + 1'b1;
      if (r_state == WAIT_HI && bus.add_rdy)
        r_err <= 1'b0;
      else if (w_fail)
        r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_fail  = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.gnt    = r_gnt;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.busy   = (r_state != IDLE);
  assign bus.add_cs = r_cs;
  assign bus.add_x  = r_x;
  assign bus.add_y  = r_y;
endmodule

// File: tb/tb_add_sched.sv
// Directed bench for add_sched with a behavioural 3-state sign-magnitude adder on the shared port.
module tb_add_sched;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TMO = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stuck = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  add_sched_if #(.N_REQ(N), .W(W)) bus();

  add_sched #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [15:0] sm_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] s;
    if (x[15] == y[15])         s = {x[15], x[14:0] + y[14:0]};
    else if (x[14:0] >= y[14:0]) s = {x[15], x[14:0] - y[14:0]};
    else                         s = {y[15], y[14:0] - x[14:0]};
    if (s[14:0] == 15'd0) s = 16'h0000;
    return s;
  endfunction

  // Adder: rdy drops the cycle after cs, stays low two cycles, then returns with the sum.
  logic        a_busy;
  logic        a_cnt;
  logic [15:0] a_x, a_y;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.add_rdy <= 1'b1;
      bus.add_sum <= '0;
      a_busy      <= 1'b0;
      a_cnt       <= 1'b0;
      a_x         <= '0;
      a_y         <= '0;
    end else if (stuck) begin
      bus.add_rdy <= 1'b1;
    end else if (bus.add_cs) begin
      bus.add_rdy <= 1'b0;
      a_busy      <= 1'b1;
      a_cnt       <= 1'b1;
      a_x         <= bus.add_x;
      a_y         <= bus.add_y;
    end else if (a_busy) begin
      if (a_cnt) a_cnt <= 1'b0;
      else begin
        bus.add_rdy <= 1'b1;
        bus.add_sum <= sm_add(a_x, a_y);
        a_busy      <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done == '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    while (bus.gnt == '0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic fill_ops();
    for (int i = 0; i < N; i++) begin
      bus.op_a[i*W +: W] = 16'h5A5A;
      bus.op_b[i*W +: W] = 16'hA5A5;
    end
  endtask

  typedef struct {
    logic [N-1:0] req;
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    bit           drop;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int cyc;
    fill_ops();
    bus.op_a[v.idx*W +: W] = v.a;
    bus.op_b[v.idx*W +: W] = v.b;
    bus.req = v.req;
    @(negedge clk);
    chk("gnt", 32'(bus.gnt), 32'(v.req));
    chk("add_cs_hi", 32'(bus.add_cs), 32'd1);
    chk("add_x", 32'(bus.add_x), 32'(v.a));
    chk("add_y", 32'(bus.add_y), 32'(v.b));
    chk("busy_hi", 32'(bus.busy), 32'd1);
    bus.op_a[v.idx*W +: W] = 16'h7FFF;
    bus.op_b[v.idx*W +: W] = 16'h7FFF;
    if (v.drop) bus.req = '0;
    @(negedge clk);
    chk("add_cs_lo", 32'(bus.add_cs), 32'd0);
    wait_done(cyc);
    chk("latency", 32'(cyc + 3), 32'd6);
    chk("done", 32'(bus.done), 32'(v.req));
    chk("result", 32'(bus.result), 32'(v.exp_res));
    chk("err", 32'(bus.err), 32'd0);
    chk("add_x_stable", 32'(bus.add_x), 32'(v.a));
    bus.req = '0;
    @(negedge clk);
    chk("done_clr", 32'(bus.done), 32'd0);
    chk("gnt_clr", 32'(bus.gnt), 32'd0);
    chk("busy_lo", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [N-1:0] eg;
    vecs[0] = '{req: 4'b0001, idx: 0, a: 16'h0005, b: 16'h0003, exp_res: 16'h0008, drop: 1'b0};
    vecs[1] = '{req: 4'b0010, idx: 1, a: 16'h8005, b: 16'h0003, exp_res: 16'h8002, drop: 1'b0};
    vecs[2] = '{req: 4'b0100, idx: 2, a: 16'h0003, b: 16'h8005, exp_res: 16'h8002, drop: 1'b0};
    vecs[3] = '{req: 4'b1000, idx: 3, a: 16'h8004, b: 16'h8004, exp_res: 16'h8008, drop: 1'b0};
    vecs[4] = '{req: 4'b0001, idx: 0, a: 16'h0007, b: 16'h8007, exp_res: 16'h0000, drop: 1'b1};
    vecs[5] = '{req: 4'b0010, idx: 1, a: 16'h1234, b: 16'h0111, exp_res: 16'h1345, drop: 1'b1};

    bus.req = '0;
    fill_ops();
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_add_cs", 32'(bus.add_cs), 32'd0);
    chk("rst_add_xy", 32'({bus.add_x, bus.add_y}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_gnt", 32'(bus.gnt), 32'd0);
    chk("idle_cs", 32'(bus.add_cs), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while waiting for the sum: abort without done, then lowest active requester wins.
    fill_ops();
    bus.op_a[1*W +: W] = 16'h0002;
    bus.op_b[1*W +: W] = 16'h0002;
    bus.req = 4'b1000;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    chk("pre_rst_rdy", 32'(bus.add_rdy), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({bus.gnt, bus.done, bus.err, bus.busy, bus.add_cs}), 32'd0);
    chk("mid_rst_data", 32'({bus.result, bus.add_x}), 32'd0);
    chk("mid_rst_y", 32'(bus.add_y), 32'd0);
    bus.req = 4'b1010;
    @(negedge clk);
    chk("rst_no_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", 32'(bus.gnt), 32'b0010);
    chk("post_rst_no_done", 32'(bus.done), 32'd0);
    bus.req = 4'b0010;
    wait_done(cyc);
    chk("post_rst_done", 32'(bus.done), 32'b0010);
    chk("post_rst_result", 32'(bus.result), 32'h0004);
    bus.req = '0;
    @(negedge clk);

    // Fairness with every requester asserted continuously.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.op_a[i*W +: W] = 16'(i + 1);
      bus.op_b[i*W +: W] = 16'h0010;
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(cyc);
      eg = N'(1) << (k % N);
      chk("rr_gnt", 32'(bus.gnt), 32'(eg));
      wait_done(cyc);
      chk("rr_done", 32'(bus.done), 32'(eg));
      chk("rr_result", 32'(bus.result), 32'(16'h0011 + 16'(k % N)));
      @(negedge clk);
    end
    bus.req = '0;
    repeat (8) @(negedge clk);

`ifdef ADD_SCHED_TIMEOUT_EN
    stuck = 1'b1;
    fill_ops();
    bus.op_a[0 +: W] = 16'h0005;
    bus.op_b[0 +: W] = 16'h0003;
    bus.req = 4'b0001;
    repeat (2) @(negedge clk);
    wait_done(cyc);
    chk("tmo_cycles", 32'(cyc), 32'(TMO));
    chk("tmo_done", 32'(bus.done), 32'b0001);
    chk("tmo_err", 32'(bus.err), 32'd1);
    chk("tmo_result", 32'(bus.result), 32'h0000);
    bus.req = '0;
    stuck = 1'b0;
    @(negedge clk);
    run_vec(vecs[1]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
